// File: rtl/modelado_pkg.sv
// Shared character codes and writer FSM state type for the Modelado binary-text format.
package modelado_pkg;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_ONE  = 8'h31;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;

  typedef enum logic [1:0] {IDLE, BITS, CR, NL} writer_state_t;

  function automatic logic [7:0] bit_char(input logic b);
    return b ? CHAR_ONE : CHAR_ZERO;
  endfunction

endpackage

// File: rtl/bin_line_writer_if.sv
// Word input stream and byte output stream of the binary-text line writer.
interface bin_line_writer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_char
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_char
  );
endinterface

// File: rtl/bin_word_fifo.sv
// Synchronous word FIFO; pointers carry an extra wrap bit to tell full from empty.
module bin_word_fifo #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; resetting the pointers already makes every entry invalid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bin_line_writer.sv
// Prints buffered words as lines of ASCII '0'/'1' (MSB first) plus a line terminator.
module bin_line_writer
  import modelado_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit EMIT_CR    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  bin_line_writer_if.slave   bus,
  output logic               busy,
  output logic [15:0]        words_done
);
  localparam int CNT_W = $clog2(WIDTH);

  writer_state_t    state;
  logic [WIDTH-2:0] sreg;       // bits not yet moved into out_char
  logic [CNT_W-1:0] bit_cnt;
  logic             out_valid_r;
  logic [7:0]       out_char_r;

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             hs;

  assign bus.in_ready  = !fifo_full;
  assign push          = bus.in_valid && !fifo_full;
  assign hs            = out_valid_r && bus.out_ready;
  assign pop           = !fifo_empty && ((state == IDLE) || (state == NL && hs));
  assign bus.out_valid = out_valid_r;
  assign bus.out_char  = out_char_r;
  assign busy          = (state != IDLE) || !fifo_empty;

  bin_word_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Popping in NL on the terminator handshake chains lines with no idle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      out_valid_r <= 1'b0;
      out_char_r  <= 8'h00;
      words_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sreg        <= fifo_head[WIDTH-2:0];
            bit_cnt     <= CNT_W'(WIDTH-1);
            out_valid_r <= 1'b1;
            out_char_r  <= bit_char(fifo_head[WIDTH-1]);
            state       <= BITS;
          end
        end
        BITS: begin
          if (hs) begin
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt - CNT_W'(1);
            if (bit_cnt == '0) begin
              state      <= EMIT_CR ? CR : NL;
              out_char_r <= EMIT_CR ? CHAR_CR : CHAR_LF;
            end else begin
              out_char_r <= bit_char(sreg[WIDTH-2]);
            end
          end
        end
        CR: begin
          if (hs) begin
            state      <= NL;
            out_char_r <= CHAR_LF;
          end
        end
        NL: begin
          if (hs) begin
            words_done <= words_done + 16'd1;
            if (!fifo_empty) begin
              sreg       <= fifo_head[WIDTH-2:0];
              bit_cnt    <= CNT_W'(WIDTH-1);
              out_char_r <= bit_char(fifo_head[WIDTH-1]);
              state      <= BITS;
            end else begin
              out_valid_r <= 1'b0;
              out_char_r  <= 8'h00;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_line_writer.sv
// Directed bench for bin_line_writer: an LF-only instance plus a CR+LF instance.
module tb_bin_line_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bin_line_writer_if #(.WIDTH(32)) b1 ();
  bin_line_writer_if #(.WIDTH(32)) b2 ();

  logic        busy_lf, busy_cr;
  logic [15:0] wd_lf, wd_cr;

  bin_line_writer #(.WIDTH(32), .FIFO_DEPTH(4), .EMIT_CR(1'b0)) dut_lf (
    .clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy_lf), .words_done(wd_lf)
  );

  bin_line_writer #(.WIDTH(32), .FIFO_DEPTH(4), .EMIT_CR(1'b1)) dut_cr (
    .clk(clk), .rst_n(rst_n), .bus(b2), .busy(busy_cr), .words_done(wd_cr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int stall_errs;
  int gaps;

  task automatic add_line(input logic [31:0] w, input bit cr);
    for (int i = 31; i >= 0; i--) exp_q.push_back(w[i] ? 8'h31 : 8'h30);
    if (cr) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  function automatic int first_mismatch();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic set_ready(input bit sel, input logic r);
    if (sel) b2.out_ready = r; else b1.out_ready = r;
  endtask

  // Present one word, waiting a bounded time for in_ready first.
  task automatic push_word(input bit sel, input logic [31:0] w);
    for (int t = 0; t < 200; t++) begin
      if (sel ? b2.in_ready : b1.in_ready) break;
      @(posedge clk); #1;
    end
    if (sel) begin b2.in_valid = 1'b1; b2.in_data = w; end
    else     begin b1.in_valid = 1'b1; b1.in_data = w; end
    @(posedge clk); #1;
    if (sel) b2.in_valid = 1'b0; else b1.in_valid = 1'b0;
  endtask

  // Collect n transferred bytes; records stalled-cycle instability and idle gaps.
  task automatic drain(input bit sel, input int n, input bit rnd);
    logic       rdy, v, prev_stall;
    logic [7:0] c, prev_char;
    bit         started;
    got.delete();
    stall_errs = 0;
    gaps       = 0;
    started    = 0;
    prev_stall = 1'b0;
    prev_char  = 8'h00;
    for (int cyc = 0; cyc < 20000 && got.size() < n; cyc++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(sel, rdy);
      v = sel ? b2.out_valid : b1.out_valid;
      c = sel ? b2.out_char  : b1.out_char;
      if (prev_stall && (v !== 1'b1 || c !== prev_char)) stall_errs++;
      if (v) started = 1;
      else if (started) gaps++;
      if (v && rdy) got.push_back(c);
      prev_stall = v && !rdy;
      prev_char  = c;
      @(posedge clk); #1;
    end
    set_ready(sel, 1'b0);
  endtask

  task automatic report_bytes(input string name);
    int mm;
    mm = first_mismatch();
    n_checks++;
    if (mm != -1)
      $display("FAIL %s: byte %0d got %h expected %h (got %0d bytes, expected %0d)", name, mm,
               (mm < got.size()) ? got[mm] : 8'hxx, (mm < exp_q.size()) ? exp_q[mm] : 8'hxx,
               got.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (b1.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", b1.out_valid); else n_pass++;
    n_checks++; if (b1.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", b1.in_ready); else n_pass++;
    n_checks++; if (busy_lf !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_lf); else n_pass++;
    n_checks++; if (wd_lf !== 16'd0) $display("FAIL reset_words_done: got %0d expected 0", wd_lf); else n_pass++;
    n_checks++; if (b1.out_char !== 8'h00) $display("FAIL reset_out_char: got %h expected 00", b1.out_char); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    string s;
    s = "00000000000000111100100110011011";
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
    push_word(0, 32'h0003C99B);
    n_checks++; if (b1.out_valid !== 1'b0) $display("FAIL single_latency_early: out_valid got %b expected 0", b1.out_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (b1.out_valid !== 1'b1 || b1.out_char !== 8'h30)
      $display("FAIL single_first_char: valid/char got %b/%h expected 1/30", b1.out_valid, b1.out_char); else n_pass++;
    drain(0, 33, 0);
    report_bytes("single_bytes");
    n_checks++; if (wd_lf !== 16'd1) $display("FAIL single_words_done: got %0d expected 1", wd_lf); else n_pass++;
    n_checks++; if (busy_lf !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy_lf); else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    add_line(32'h0003C99B, 0);
    push_word(0, 32'h0003C99B);
    drain(0, 33, 1);
    report_bytes("bp_bytes");
    n_checks++; if (stall_errs !== 0) $display("FAIL bp_stall_stable: unstable stalled cycles got %0d expected 0", stall_errs); else n_pass++;
    n_checks++; if (wd_lf !== 16'd2) $display("FAIL bp_words_done: got %0d expected 2", wd_lf); else n_pass++;
  endtask

  task automatic test_fill();
    logic [31:0] wf[7];
    int acc;
    wf = '{32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'hA5A5A5A5,
           32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D};
    acc = 0;
    b1.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b1.in_valid = 1'b1;
      b1.in_data  = wf[i];
      if (b1.in_ready) acc++;
      @(posedge clk); #1;
    end
    b1.in_valid = 1'b0;
    n_checks++; if (acc !== 5) $display("FAIL fill_accepted: got %0d expected 5", acc); else n_pass++;
    n_checks++; if (b1.in_ready !== 1'b0) $display("FAIL fill_in_ready_low: got %b expected 0", b1.in_ready); else n_pass++;
    exp_q.delete();
    for (int i = 0; i < 5; i++) add_line(wf[i], 0);
    drain(0, 165, 0);
    report_bytes("fill_bytes");
    n_checks++; if (b1.in_ready !== 1'b1) $display("FAIL fill_in_ready_back: got %b expected 1", b1.in_ready); else n_pass++;
    n_checks++; if (wd_lf !== 16'd7) $display("FAIL fill_words_done: got %0d expected 7", wd_lf); else n_pass++;
  endtask

  task automatic test_back_to_back(input bit sel);
    int nb;
    logic [15:0] wd_exp;
    nb = sel ? 102 : 99;
    wd_exp = sel ? 16'd3 : 16'd10;
    exp_q.delete();
    add_line(32'h00000001, sel);
    add_line(32'h7FFFFFFF, sel);
    add_line(32'h5555AAAA, sel);
    fork
      begin
        push_word(sel, 32'h00000001);
        push_word(sel, 32'h7FFFFFFF);
        push_word(sel, 32'h5555AAAA);
      end
      drain(sel, nb, 0);
    join
    report_bytes(sel ? "b2b_cr_bytes" : "b2b_bytes");
    n_checks++; if (gaps !== 0) $display("FAIL b2b_gaps sel=%0d: idle cycles got %0d expected 0", sel, gaps); else n_pass++;
    n_checks++; if ((sel ? wd_cr : wd_lf) !== wd_exp)
      $display("FAIL b2b_words_done sel=%0d: got %0d expected %0d", sel, sel ? wd_cr : wd_lf, wd_exp); else n_pass++;
  endtask

  task automatic test_mid_reset();
    fork
      begin
        push_word(0, 32'h0F0F0F0F);
        push_word(0, 32'h33333333);
        push_word(0, 32'hCCCCCCCC);
      end
      drain(0, 10, 0);
    join
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (b1.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", b1.out_valid); else n_pass++;
    n_checks++; if (busy_lf !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_lf); else n_pass++;
    n_checks++; if (wd_lf !== 16'd0) $display("FAIL midrst_words_done: got %0d expected 0", wd_lf); else n_pass++;
    n_checks++; if (b1.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", b1.in_ready); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    add_line(32'hC0FFEE01, 0);
    push_word(0, 32'hC0FFEE01);
    drain(0, 33, 0);
    report_bytes("midrst_clean_line");
    n_checks++; if (wd_lf !== 16'd1) $display("FAIL midrst_after_words_done: got %0d expected 1", wd_lf); else n_pass++;
    n_checks++; if (busy_lf !== 1'b0) $display("FAIL midrst_after_busy: got %b expected 0", busy_lf); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_back_to_back(0);
    test_back_to_back(1);
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
